add_test_sequencer: RTL and testbench

ADD_TEST_SEQUENCER -- requirements
Module: add_test_sequencer

---
 rtl/add_test_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_add_test_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/add_test_sequencer.sv
// Purpose: register-driven sequencer. It issues COUNT operand-RAM reads from
//          START_ADDR and replays each one as a result-RAM write after a fixed delay.
// Latency: the first r_en comes on the cycle after pll_lock is seen high. Each we/w_addr
//          follows its r_en/r_addr by exactly LATENCY cycles.
// Backpressure: none. Abort, a pll_lock drop or reset ends a run at once and
//               cancels the writes still in flight.
// Ports:
//   pll_clock, resetn        sole clock; asynchronous active-low reset
//   read, write, address,    single-cycle register strobes. readdata is registered
//   writedata, readdata      and is valid one cycle after read.
//   pll_lock                 gates the start of issue; a drop during a run is an error
//   r_addr/r_en              registered operand read address and its valid
//   w_addr/we                delayed copy of r_addr/r_en, used as the result write
//   busy                     high whenever the sequencer is not idle
module add_test_sequencer #(
  parameter int ADDR_WIDTH = 11,
  parameter int LATENCY    = 8,
  parameter int ID         = 9
) (
  input  logic                  pll_clock,
  input  logic                  resetn,
  input  logic                  read,
  input  logic                  write,
  input  logic [2:0]            address,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic                  pll_lock,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  r_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic                  we,
  output logic                  busy
);

  localparam int CW = ADDR_WIDTH + 1;
  // Selects every shift-line stage except the oldest. This mask is empty when LATENCY is 1.
  localparam logic [LATENCY-1:0] YOUNGER_MASK = {LATENCY{1'b1}} >> 1;

  typedef enum logic [1:0] {IDLE, WAIT_LOCK, ISSUE, DRAIN} state_t;

  state_t                                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]                  start_addr_q, start_addr_d;
  logic [CW-1:0]                          count_q, count_d;
  logic [CW-1:0]                          issued_q, issued_d;
  logic [31:0]                            cycles_q, cycles_d;
  logic                                   done_q, done_d;
  logic                                   error_q, error_d;
  logic                                   r_en_q, r_en_d;
  logic [ADDR_WIDTH-1:0]                  r_addr_q, r_addr_d;
  logic [LATENCY-1:0]                     sh_vld_q, sh_vld_d;
  logic [LATENCY-1:0][ADDR_WIDTH-1:0]     sh_addr_q, sh_addr_d;
  logic [31:0]                            rdata_q, rdata_d;

  logic wr_ctrl, start_req, abort_req, last_we, kill;
  logic unused_wdata;

  assign unused_wdata = ^writedata[31:CW];

  assign wr_ctrl   = write && (address == 3'd0);
  assign abort_req = wr_ctrl && writedata[1];
  // When abort and start are written together, abort takes priority.
  assign start_req = wr_ctrl && writedata[0] && !writedata[1];

  // The run is contiguous. So the last write is the oldest stage, with no younger
  // stage and no new read still behind it.
  assign last_we = sh_vld_q[LATENCY-1] && ((sh_vld_q & YOUNGER_MASK) == '0) && !r_en_q;

  assign busy     = (state_q != IDLE);
  assign r_en     = r_en_q;
  assign r_addr   = r_addr_q;
  assign we       = sh_vld_q[LATENCY-1];
  assign w_addr   = sh_addr_q[LATENCY-1];
  assign readdata = rdata_q;

  always_comb begin
    state_d      = state_q;
    start_addr_d = start_addr_q;
    count_d      = count_q;
    issued_d     = issued_q;
    cycles_d     = cycles_q;
    done_d       = done_q;
    error_d      = error_q;
    r_en_d       = 1'b0;
    r_addr_d     = r_addr_q;
    kill         = 1'b0;

    sh_vld_d[0]  = r_en_q;
    sh_addr_d[0] = r_addr_q;
    for (int k = 1; k < LATENCY; k++) begin
      sh_vld_d[k]  = sh_vld_q[k-1];
      sh_addr_d[k] = sh_addr_q[k-1];
    end

    // The run configuration is frozen while a run is active.
    if (write && !busy) begin
      if (address == 3'd1) start_addr_d = writedata[ADDR_WIDTH-1:0];
      if (address == 3'd2) count_d      = writedata[CW-1:0];
    end

    case (state_q)
      IDLE: begin
        if (start_req) begin
          if (count_q == '0) begin
            done_d = 1'b1;
          end else begin
            done_d   = 1'b0;
            error_d  = 1'b0;
            cycles_d = '0;
            state_d  = WAIT_LOCK;
          end
        end
      end
      WAIT_LOCK: begin
        if (abort_req) begin
          kill = 1'b1;
        end else if (pll_lock) begin
          state_d  = ISSUE;
          r_en_d   = 1'b1;
          r_addr_d = start_addr_q;
          issued_d = CW'(1);
        end
      end
      ISSUE: begin
        cycles_d = (cycles_q == '1) ? cycles_q : cycles_q + 32'd1;
        if (abort_req || !pll_lock) begin
          kill = 1'b1;
        end else if (issued_q < count_q) begin
          r_en_d   = 1'b1;
          r_addr_d = r_addr_q + 1'b1;
          issued_d = issued_q + 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        cycles_d = (cycles_q == '1) ? cycles_q : cycles_q + 32'd1;
        if (abort_req || !pll_lock) begin
          kill = 1'b1;
        end else if (last_we) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Ending a run early cancels every write still in the shift line.
    // A pll_lock drop is the only way to end a run early that also flags an error.
    if (kill) begin
      state_d  = IDLE;
      r_en_d   = 1'b0;
      sh_vld_d = '0;
      done_d   = 1'b0;
      if (!pll_lock && (state_q != WAIT_LOCK)) error_d = 1'b1;
    end

    rdata_d = '0;
    if (read) begin
      case (address)
        3'd0:    rdata_d[3:0]            = {error_q, pll_lock, done_q, busy};
        3'd1:    rdata_d[ADDR_WIDTH-1:0] = start_addr_q;
        3'd2:    rdata_d[CW-1:0]         = count_q;
        3'd3:    rdata_d                 = cycles_q;
        3'd4:    rdata_d                 = 32'(ID);
        default: rdata_d                 = '0;
      endcase
    end
  end

  always_ff @(posedge pll_clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      start_addr_q <= '0;
      count_q      <= '0;
      issued_q     <= '0;
      cycles_q     <= '0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      r_en_q       <= 1'b0;
      r_addr_q     <= '0;
      sh_vld_q     <= '0;
      sh_addr_q    <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      start_addr_q <= start_addr_d;
      count_q      <= count_d;
      issued_q     <= issued_d;
      cycles_q     <= cycles_d;
      done_q       <= done_d;
      error_q      <= error_d;
      r_en_q       <= r_en_d;
      r_addr_q     <= r_addr_d;
      sh_vld_q     <= sh_vld_d;
      sh_addr_q    <= sh_addr_d;
      rdata_q      <= rdata_d;
    end
  end

endmodule

// File: tb/tb_add_test_sequencer.sv
// Bench for add_test_sequencer. Its model predicts, for each run, the cycle of
// every read and write from the start strobe, the lock delay and the interruption point.
module tb_add_test_sequencer;
  localparam int AW  = 11;
  localparam int LAT = 8;
  localparam int IDV = 9;

  logic          pll_clock = 1'b0;
  logic          resetn    = 1'b0;
  logic          read      = 1'b0;
  logic          write     = 1'b0;
  logic          pll_lock  = 1'b0;
  logic [2:0]    address   = '0;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic [AW-1:0] r_addr, w_addr;
  logic          r_en, we, busy;

  int n_chk  = 0;
  int n_fail = 0;

  add_test_sequencer #(.ADDR_WIDTH(AW), .LATENCY(LAT), .ID(IDV)) dut (
    .pll_clock (pll_clock),
    .resetn    (resetn),
    .read      (read),
    .write     (write),
    .address   (address),
    .writedata (writedata),
    .readdata  (readdata),
    .pll_lock  (pll_lock),
    .r_addr    (r_addr),
    .r_en      (r_en),
    .w_addr    (w_addr),
    .we        (we),
    .busy      (busy)
  );

  always #5 pll_clock = ~pll_clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pll_clock);
    #1;
  endtask

  task automatic reg_wr(input logic [2:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write     = 1'b1;
    tick();
    write     = 1'b0;
  endtask

  task automatic reg_rd(input logic [2:0] a, output logic [31:0] d);
    address = a;
    read    = 1'b1;
    tick();
    read    = 1'b0;
    d       = readdata;
  endtask

  // mode 0: run to completion. mode 1: drop pll_lock during the k-th read.
  // mode 2: write abort during the k-th read. d = number of cycles lock stays low after start.
  task automatic run_seq(input int s, input int n, input int d, input int mode,
                         input int k, input string tag);
    int f, x, last;
    logic          er, ew;
    logic [AW-1:0] ea;
    logic [31:0]   v;
    reg_wr(3'd1, 32'(s));
    reg_wr(3'd2, 32'(n));
    pll_lock = (d == 0);
    reg_wr(3'd0, 32'd1);                 // start strobe is cycle 0; we are now in cycle 1
    f    = d + 2;                         // first r_en: one cycle after lock is sampled high
    x    = (mode == 0) ? f + n + LAT : f + k;  // first idle cycle
    last = (mode == 0) ? x : f + k + LAT + 2;
    for (int c = 1; c <= last; c++) begin
      pll_lock = (c > d) && !(mode == 1 && c >= f + k - 1);
      if (mode == 2 && c == f + k - 1) begin
        address   = 3'd0;
        writedata = 32'd2;
        write     = 1'b1;
      end else begin
        write = 1'b0;
      end
      er = (c >= f) && (c < f + n) && (c < x);
      ew = (c >= f + LAT) && (c < f + LAT + n) && (c < x);
      check({tag, " r_en"}, r_en, er);
      if (er) begin
        ea = AW'(s + c - f);
        check({tag, " r_addr"}, r_addr, ea);
      end
      check({tag, " we"}, we, ew);
      if (ew) begin
        ea = AW'(s + c - f - LAT);
        check({tag, " w_addr"}, w_addr, ea);
      end
      check({tag, " busy"}, busy, c < x);
      tick();
    end
    write = 1'b0;
    reg_rd(3'd0, v);
    case (mode)
      0:       check({tag, " ctrl"}, v, 32'h6);
      1:       check({tag, " ctrl"}, v, 32'h8);
      default: check({tag, " ctrl"}, v, 32'h4);
    endcase
    if (mode == 0) begin
      reg_rd(3'd3, v);
      check({tag, " cycles"}, v, 32'(n + LAT));
    end
    pll_lock = 1'b1;
  endtask

  initial begin
    logic [31:0] v;
    int s, n, d, m, k;

    // Power-up reset
    tick();
    tick();
    check("rst r_en", r_en, 0);
    check("rst we", we, 0);
    check("rst busy", busy, 0);
    check("rst r_addr", r_addr, 0);
    check("rst w_addr", w_addr, 0);
    check("rst readdata", readdata, 0);
    resetn = 1'b1;
    tick();
    reg_rd(3'd0, v);
    check("ctrl nolock", v, 0);
    pll_lock = 1'b1;
    reg_rd(3'd0, v);
    check("ctrl lock", v, 32'h4);
    reg_rd(3'd4, v);
    check("id", v, IDV);
    reg_rd(3'd5, v);
    check("addr5", v, 0);
    reg_rd(3'd7, v);
    check("addr7", v, 0);

    // Directed runs
    run_seq(5, 3, 0, 0, 0, "basic");
    reg_wr(3'd3, 32'h55);              // writes to CYCLES are ignored
    reg_rd(3'd3, v);
    check("cycles ro", v, 11);
    run_seq(2046, 4, 0, 0, 0, "wrap");
    run_seq(100, 5, 10, 0, 0, "lockwait");
    run_seq(300, 20, 0, 1, 5, "drop5");
    run_seq(300, 20, 0, 2, 5, "abort5");
    run_seq(700, 20, 0, 1, 12, "drop12");
    run_seq(700, 20, 0, 2, 12, "abort12");

    // COUNT=0 start, issued while done is still 0 from the aborted run above
    reg_wr(3'd2, 32'd0);
    reg_wr(3'd0, 32'd1);
    check("cnt0 busy", busy, 0);
    check("cnt0 r_en", r_en, 0);
    reg_rd(3'd0, v);
    check("cnt0 ctrl", v, 32'h6);
    for (int c = 0; c < LAT + 2; c++) begin
      check("cnt0 busy", busy, 0);
      check("cnt0 r_en", r_en, 0);
      check("cnt0 we", we, 0);
      tick();
    end

    // Configuration writes and start are ignored while busy
    pll_lock = 1'b0;
    reg_wr(3'd1, 32'd100);
    reg_wr(3'd2, 32'd5);
    reg_wr(3'd0, 32'd1);
    check("hold busy", busy, 1);
    reg_wr(3'd1, 32'd7);
    reg_wr(3'd2, 32'd9);
    reg_wr(3'd0, 32'd1);
    reg_rd(3'd1, v);
    check("hold start_addr", v, 100);
    reg_rd(3'd2, v);
    check("hold count", v, 5);
    reg_wr(3'd0, 32'd2);
    check("abort in wait", busy, 0);
    pll_lock = 1'b1;
    reg_wr(3'd0, 32'd3);               // abort and start together: abort wins
    check("abort+start busy", busy, 0);
    tick();
    check("abort+start r_en", r_en, 0);

    // Full-range run: COUNT=2^AW wraps through every address
    run_seq(1000, 1 << AW, 0, 0, 0, "full");

    // Randomised runs
    for (int i = 0; i < 10; i++) begin
      s = $urandom_range(0, (1 << AW) - 1);
      n = $urandom_range(1, 24);
      d = $urandom_range(0, 4);
      m = (n > 1) ? $urandom_range(0, 2) : 0;
      k = (n > 1) ? $urandom_range(1, n - 1) : 0;
      run_seq(s, n, d, m, k, "rand");
    end

    // Reset asserted mid-run
    reg_wr(3'd1, 32'd40);
    reg_wr(3'd2, 32'd50);
    reg_wr(3'd0, 32'd1);
    for (int c = 0; c < 20; c++) tick();
    check("mid we active", we, 1);
    resetn = 1'b0;
    #1;
    check("mid rst r_en", r_en, 0);
    check("mid rst we", we, 0);
    check("mid rst busy", busy, 0);
    check("mid rst r_addr", r_addr, 0);
    check("mid rst w_addr", w_addr, 0);
    tick();
    tick();
    resetn = 1'b1;
    for (int c = 0; c < LAT + 4; c++) begin
      tick();
      check("post rst we", we, 0);
      check("post rst r_en", r_en, 0);
      check("post rst busy", busy, 0);
    end
    reg_rd(3'd1, v);
    check("post rst start_addr", v, 0);
    reg_rd(3'd2, v);
    check("post rst count", v, 0);
    reg_rd(3'd3, v);
    check("post rst cycles", v, 0);
    reg_rd(3'd0, v);
    check("post rst ctrl", v, 32'h4);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
